// File: rtl/router_input_fifo_if.sv
// Flit-input bundle for router_input_fifo: DRTS/CTS write handshake, per-arbiter pop
// requests and the show-ahead head/status outputs.
interface router_input_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] RX;
  logic                  DRTS;
  logic                  CTS;
  logic                  read_en_N;
  logic                  read_en_E;
  logic                  read_en_W;
  logic                  read_en_S;
  logic                  read_en_L;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  empty;
  logic                  full;
  logic [PTR_W:0]        count;
  logic                  err_multi_read;

  modport master (
    output RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    input  CTS, Data_out, empty, full, count, err_multi_read
  );

  modport slave (
    input  RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    output CTS, Data_out, empty, full, count, err_multi_read
  );
endinterface

// File: rtl/router_input_fifo.sv
// Per-input-port circular flit buffer: accepts flits over DRTS/CTS, presents the head
// show-ahead and pops once per cycle on any arbiter grant.
module router_input_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                rst,
  router_input_fifo_if.slave bus
);
  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  cts_q, cts_d;
  logic                  err_q, err_d;

  logic [4:0] rd_vec;
  logic       read_any;
  logic       multi_read;
  logic       empty;
  logic       full;
  logic       do_write;
  logic       do_pop;

  assign rd_vec     = {bus.read_en_N, bus.read_en_E, bus.read_en_W, bus.read_en_S,
                       bus.read_en_L};
  assign read_any   = |rd_vec;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_read = (rd_vec & (rd_vec - 5'd1)) != 5'd0;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FullCount);
  // CTS is only ever issued while not full, so the write needs no occupancy check.
  assign do_write = cts_q & bus.DRTS;
  assign do_pop   = read_any & ~empty;

  always_comb begin
    cts_d    = bus.DRTS & ~cts_q & ~full;
    err_d    = multi_read;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_write) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_write, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      cts_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cts_q    <= cts_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; a reset during the CTS cycle must still drop the pending flit.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem_q[wr_ptr_q] <= bus.RX;
    end
  end

  assign bus.CTS            = cts_q;
  assign bus.Data_out       = mem_q[rd_ptr_q];
  assign bus.empty          = empty;
  assign bus.full           = full;
  assign bus.count          = count_q;
  assign bus.err_multi_read = err_q;
endmodule

// File: tb/tb_router_input_fifo.sv
// Directed bench for router_input_fifo: stimulus pushes expected flits into a queue and a
// negedge monitor checks Data_out against the queue head on every pop.
module tb_router_input_fifo;
  logic       clk;
  logic       rst;
  logic [4:0] rd_en;  // {N, E, W, S, L}
  int         total;
  int         bad;
  logic [31:0] exp_q[$];

  router_input_fifo_if #(.DATA_WIDTH(32), .DEPTH(4)) bus ();

  router_input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.read_en_N = rd_en[4];
  assign bus.read_en_E = rd_en[3];
  assign bus.read_en_W = rd_en[2];
  assign bus.read_en_S = rd_en[1];
  assign bus.read_en_L = rd_en[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a grant against a non-empty model must show the model head.
  always @(negedge clk) begin
    if (!rst && (|rd_en) && exp_q.size() > 0) begin
      chk("pop_data", bus.Data_out, exp_q[0]);
      void'(exp_q.pop_front());
    end
  end

  task automatic send(input logic [31:0] d);
    @(posedge clk); #1;
    bus.RX   = d;
    bus.DRTS = 1'b1;
    @(negedge clk); chk("cts_t", 32'(bus.CTS), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("cts_t1", 32'(bus.CTS), 32'd1);
    @(posedge clk);
    exp_q.push_back(d);
    #1;
    bus.DRTS = 1'b0;
    @(negedge clk); chk("cts_t2", 32'(bus.CTS), 32'd0);
  endtask

  task automatic rd(input logic [4:0] en);
    @(posedge clk); #1;
    rd_en = en;
    @(posedge clk); #1;
    rd_en = '0;
  endtask

  task automatic check_count();
    @(negedge clk);
    chk("count_model", 32'(bus.count), 32'(exp_q.size()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] ops;
    logic [31:0] nxt;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    rd_en    = '0;
    bus.RX   = '0;
    bus.DRTS = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_cts", 32'(bus.CTS), 32'd0);
      chk("idle_empty", 32'(bus.empty), 32'd1);
      chk("idle_full", 32'(bus.full), 32'd0);
      chk("idle_count", 32'(bus.count), 32'd0);
      chk("idle_err", 32'(bus.err_multi_read), 32'd0);
    end

    // Single flit
    send(32'hA5A5_0001);
    chk("single_count", 32'(bus.count), 32'd1);
    chk("single_empty", 32'(bus.empty), 32'd0);
    chk("single_data", bus.Data_out, 32'hA5A5_0001);
    rd(5'b00001);
    @(negedge clk);
    chk("single_empty2", 32'(bus.empty), 32'd1);
    chk("single_count2", 32'(bus.count), 32'd0);

    // Fill to full, then a blocked fifth request
    for (int i = 1; i <= 4; i++) send(32'(i));
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd4);
    @(posedge clk); #1;
    bus.RX   = 32'd5;
    bus.DRTS = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("cts_while_full", 32'(bus.CTS), 32'd0);
      @(posedge clk); #1;
    end
    rd_en = 5'b10000;
    @(negedge clk); chk("cts_pop_cycle", 32'(bus.CTS), 32'd0);
    @(posedge clk); #1;
    rd_en = '0;
    @(negedge clk);
    chk("after_pop_count", 32'(bus.count), 32'd3);
    chk("after_pop_data", bus.Data_out, 32'd2);
    chk("after_pop_cts", 32'(bus.CTS), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("refill_cts", 32'(bus.CTS), 32'd1);
    @(posedge clk);
    exp_q.push_back(32'd5);
    #1;
    bus.DRTS = 1'b0;
    @(negedge clk);
    chk("refill_count", 32'(bus.count), 32'd4);
    for (int i = 0; i < 4; i++) rd(5'b01000);
    check_count();

    // Interleaved push/pop across pointer wrap
    ops = 12'b110101010100;
    nxt = 32'h10;
    for (int i = 11; i >= 0; i--) begin
      if (ops[i]) begin
        send(nxt);
        nxt = nxt + 1;
      end else begin
        rd(5'b00010);
      end
      check_count();
    end

    // Simultaneous write and pop at count=1
    send(32'h20);
    @(posedge clk); #1;
    bus.RX   = 32'h21;
    bus.DRTS = 1'b1;
    @(negedge clk); chk("sim_cts_t", 32'(bus.CTS), 32'd0);
    @(posedge clk); #1;
    rd_en = 5'b01000;
    @(negedge clk); chk("sim_cts_t1", 32'(bus.CTS), 32'd1);
    @(posedge clk);
    exp_q.push_back(32'h21);
    #1;
    bus.DRTS = 1'b0;
    rd_en    = '0;
    @(negedge clk);
    chk("sim_count", 32'(bus.count), 32'd1);
    chk("sim_data", bus.Data_out, 32'h21);

    // Same attempt at count=4: no CTS, so only the pop happens
    send(32'h30); send(32'h31); send(32'h32);
    chk("neg_full", 32'(bus.full), 32'd1);
    @(posedge clk); #1;
    bus.RX   = 32'h99;
    bus.DRTS = 1'b1;
    rd_en    = 5'b01000;
    @(negedge clk); chk("neg_cts_q", 32'(bus.CTS), 32'd0);
    @(posedge clk); #1;
    bus.DRTS = 1'b0;
    rd_en    = '0;
    @(negedge clk);
    chk("neg_cts_q1", 32'(bus.CTS), 32'd0);
    chk("neg_count_q1", 32'(bus.count), 32'd3);
    @(negedge clk);
    chk("neg_count_q2", 32'(bus.count), 32'd3);
    for (int i = 0; i < 3; i++) rd(5'b00001);
    check_count();

    // Two grants at once: one pop, one-cycle error flag
    send(32'h40); send(32'h41);
    @(posedge clk); #1;
    rd_en = 5'b10010;
    @(negedge clk); chk("multi_err_pre", 32'(bus.err_multi_read), 32'd0);
    @(posedge clk); #1;
    rd_en = '0;
    @(negedge clk);
    chk("multi_count", 32'(bus.count), 32'd1);
    chk("multi_err", 32'(bus.err_multi_read), 32'd1);
    chk("multi_data", bus.Data_out, 32'h41);
    @(negedge clk); chk("multi_err_clr", 32'(bus.err_multi_read), 32'd0);
    rd(5'b00001);
    rd(5'b00100);
    @(negedge clk);
    chk("empty_rd_count", 32'(bus.count), 32'd0);
    chk("empty_rd_empty", 32'(bus.empty), 32'd1);
    chk("empty_rd_err", 32'(bus.err_multi_read), 32'd0);

    // Reset during the CTS cycle drops the pending flit
    @(posedge clk); #1;
    bus.RX   = 32'h77;
    bus.DRTS = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); chk("rst_cts_t1", 32'(bus.CTS), 32'd1);
    @(posedge clk); #1;
    rst      = 1'b0;
    bus.DRTS = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_cts", 32'(bus.CTS), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    send(32'h78);
    chk("rst_next_data", bus.Data_out, 32'h78);
    chk("rst_next_count", 32'(bus.count), 32'd1);
    rd(5'b00001);
    check_count();

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
